// File: rtl/uart_byte_serializer.sv
// 8N1 UART transmitter: latches one byte per tx_en and shifts it out LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_serializer #(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       tx_en,
   input  logic [7:0] tx_data,
   output logic       uart_tx,
   output logic       tx_done,
   output logic       tx_busy
);

   localparam int BIT_CYCLES = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [2:0]      bit_reg, bit_next;
   logic [7:0]      shift_reg, shift_next;
   logic            uart_tx_reg, uart_tx_next;
   logic            tx_done_reg, tx_done_next;
   logic            bit_end;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_reg     <= '0;
         shift_reg   <= '0;
         uart_tx_reg <= 1'b1;
         tx_done_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         uart_tx_reg <= uart_tx_next;
         tx_done_reg <= tx_done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg + CW'(1);
      bit_next   = bit_reg;
      shift_next = shift_reg;
      bit_end    = (cnt_reg == CNT_LAST);

      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            if (tx_en) begin
               state_next = START;
               shift_next = tx_data;
            end
         end
         START: begin
            if (bit_end) begin
               state_next = DATA;
               cnt_next   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_next = '0;
               if (bit_reg == 3'd7) begin
                  bit_next = '0;
`ifdef UART_TX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_next = STOP;
               cnt_next   = '0;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase

      // Line and done are registered from the upcoming state so the start bit
      // appears on the very edge that accepts the request.
      case (state_next)
         START:   uart_tx_next = 1'b0;
         DATA:    uart_tx_next = shift_next[bit_next];
`ifdef UART_TX_PARITY_EN
         PARITY:  uart_tx_next = ^shift_next;
`endif
         default: uart_tx_next = 1'b1;
      endcase
      tx_done_next = (state_next == STOP) && (cnt_next == CNT_LAST);
   end

   assign uart_tx = uart_tx_reg;
   assign tx_done = tx_done_reg;
   // The accept cycle itself counts as busy, so the request is flagged before the edge.
   assign tx_busy = (state_reg != IDLE) || tx_en;

endmodule

// File: doc/uart_byte_serializer.md
# uart_byte_serializer

Serial line driver for one 8N1 UART frame per request; sits directly below the multi-byte word sender in the camera-to-host report path and drives the board TX pin. Accepts a byte on a `tx_en` strobe or level, latches it, shifts it out LSB-first at a fixed baud rate, and pulses `tx_done` once per frame so the word sender can advance to its next byte.

## Interface
- `CLK_FREQ`, 50_000_000: sys_clk frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `BIT_CYCLES` (localparam): `(CLK_FREQ + BAUD/2) / BAUD`, rounded to nearest. Must be ≥ 2. Baud counter width is `$clog2(BIT_CYCLES)`.
- `sys_clk`  in  1  clock.
- `sys_rst_n`  in  1  reset: asynchronous, active-low.
- `tx_en`  in  1  start request. Sampled only in IDLE. A 1-cycle pulse or a held level are both legal.
- `tx_data`  in  8  byte to send. Latched in the cycle `tx_en` is accepted.
- `uart_tx`  out  1  serial line, registered. Idles high.
- `tx_done`  out  1  one-cycle pulse per completed frame, registered.
- `tx_busy`  out  1  high from the accept cycle through the last stop-bit cycle.

## Operation
- Reset values: `uart_tx`=1, `tx_done`=0, `tx_busy`=0, state IDLE, baud counter 0, bit index 0, shift register 0.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE:
  - `uart_tx`=1.
  - On `tx_en`=1: latch `tx_data`, go to START.
  - While not in IDLE, `tx_en` and `tx_data` are ignored.
- START: `uart_tx`=0 for BIT_CYCLES cycles.
- DATA: send bits 0..7, LSB first, BIT_CYCLES cycles each. Bit index 0..7; leave DATA when index 7 expires.
- STOP:
  - `uart_tx`=1 for BIT_CYCLES cycles.
  - `tx_done`=1 in the final STOP cycle (counter = BIT_CYCLES-1), then go to IDLE.
- The baud counter clears on every state or bit change. No fractional-baud correction.
- Why `tx_en` is ignored in the `tx_done` cycle: the state is still STOP. The upstream sender shifts its data on the edge after `tx_done`, so a held `tx_en` restarts only in the following IDLE cycle with the new byte. This prevents resending the old byte.
- Reset mid-frame: async return to reset values. `uart_tx` goes high immediately. No `tx_done` is issued for the aborted frame.

## Timing
- Accept at edge k (IDLE, `tx_en`=1) → `uart_tx` low from edge k until START expires.
- Frame length: 10·BIT_CYCLES cycles (11·BIT_CYCLES with parity), measured from the first low cycle to the end of the `tx_done` cycle.
- Back-to-back with `tx_en` held: exactly one IDLE cycle between frames. The effective stop bit is BIT_CYCLES+1 cycles.
- `tx_busy` falls on the same edge that `tx_done` falls.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP, lasting BIT_CYCLES cycles.
  - `uart_tx` = even parity bit (`^data`), so the count of ones over data+parity is even.
  - Frame is 11 bits.
- Not defined: PARITY state and parity logic are absent. Frame is 10 bits (8N1).

## Test plan
Bench uses CLK_FREQ=1_000_000, BAUD=100_000, so BIT_CYCLES=10.
- 1-cycle `tx_en`, `tx_data`=8'hA5:
  - `uart_tx` low 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles.
  - `tx_done` high exactly once, in cycle 100 after the first low cycle.
  - `tx_busy` high for 101 cycles (accept cycle through cycle 100).
- `tx_en` held high; `tx_data` changes 8'h3C → 8'hFF mid-frame:
  - First frame carries 8'h3C.
  - Next frame starts 1 IDLE cycle after `tx_done` and carries 8'hFF.
- Chained under the word sender with SEND_WIDTH=19 and word 19'h51234:
  - Three frames on the line: 8'h34, 8'h12, 8'h05.
  - Three `tx_done` pulses here, then the word sender's `tx_done` returns high.
- `sys_rst_n` low during DATA bit 3:
  - `uart_tx`=1 and `tx_busy`=0 asynchronously; no `tx_done`.
  - After release, 8'h00 transmits correctly.
- `tx_en` asserted only in the `tx_done` cycle: ignored; line stays high, `tx_busy`=0.
- With `UART_TX_PARITY_EN`:
  - 8'h07 → parity bit 1; 8'h03 → parity bit 0.
  - Frame 110 cycles; `tx_done` in cycle 110.
